// File: rtl/button_press_gen.sv
// Synthetic key driver: emits N presses of H cycles high, each followed by G cycles low.
// Outputs are registered, with 1 cycle of latency from start; start is ignored while busy and abort returns to idle on the next edge.
module button_press_gen #(
  parameter int HOLD_W = 8,
  parameter int GAP_W  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  press_count,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic              abort,
  output logic              buttonPressed,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  presses_left
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt, r_hold_cnt, w_hold_cnt_nxt, w_hold_eff;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt, r_gap_cnt, w_gap_cnt_nxt, w_gap_eff;
  logic [CNT_W-1:0]  w_left_nxt;
  logic              w_bp_nxt, w_busy_nxt, w_done_nxt;

  // Zero hold/gap are stretched to one cycle so every press is seen as a press and a release.
  assign w_hold_eff = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
  assign w_gap_eff  = (gap_cycles  == '0) ? GAP_W'(1)  : gap_cycles;

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_gap_nxt      = r_gap;
    w_hold_cnt_nxt = r_hold_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_left_nxt     = presses_left;
    w_bp_nxt       = 1'b0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        w_left_nxt = '0;
        if (start && !abort) begin
          if (press_count != '0) begin
            w_state_nxt    = PRESS;
            w_hold_nxt     = w_hold_eff;
            w_gap_nxt      = w_gap_eff;
            w_hold_cnt_nxt = w_hold_eff;
            w_left_nxt     = press_count - CNT_W'(1);
            w_bp_nxt       = 1'b1;
            w_busy_nxt     = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      PRESS: begin
        if (abort) begin
          w_state_nxt    = IDLE;
          w_left_nxt     = '0;
          w_hold_cnt_nxt = '0;
        end else if (r_hold_cnt == HOLD_W'(1)) begin
          w_state_nxt    = GAP;
          w_gap_cnt_nxt  = r_gap;
          w_hold_cnt_nxt = '0;
          w_busy_nxt     = 1'b1;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt - HOLD_W'(1);
          w_bp_nxt       = 1'b1;
          w_busy_nxt     = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          w_state_nxt   = IDLE;
          w_left_nxt    = '0;
          w_gap_cnt_nxt = '0;
        end else if (r_gap_cnt == GAP_W'(1)) begin
          w_gap_cnt_nxt = '0;
          if (presses_left != '0) begin
            w_state_nxt    = PRESS;
            w_hold_cnt_nxt = r_hold;
            w_left_nxt     = presses_left - CNT_W'(1);
            w_bp_nxt       = 1'b1;
            w_busy_nxt     = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
          w_busy_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_left_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_hold        <= '0;
      r_gap         <= '0;
      r_hold_cnt    <= '0;
      r_gap_cnt     <= '0;
      presses_left  <= '0;
      buttonPressed <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold        <= w_hold_nxt;
      r_gap         <= w_gap_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      presses_left  <= w_left_nxt;
      buttonPressed <= w_bp_nxt;
      busy          <= w_busy_nxt;
      done          <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_button_press_gen.sv
// Scoreboarded bench for button_press_gen: a timing-formula model predicts every cycle, and a monitor compares the DUT against it.
// A release detector on buttonPressed counts the pulses in the loopback checks.
module tb_button_press_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] press_count = '0;
  logic [7:0] hold_cycles = '0;
  logic [7:0] gap_cycles = '0;
  logic       buttonPressed, busy, done;
  logic [3:0] presses_left;

  button_press_gen #(.HOLD_W(8), .GAP_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .press_count(press_count),
    .hold_cycles(hold_cycles), .gap_cycles(gap_cycles), .abort(abort),
    .buttonPressed(buttonPressed), .busy(busy), .done(done), .presses_left(presses_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       bp;
    logic       busy;
    logic       done;
    logic [3:0] left;
  } obs_t;

  obs_t q[$];
  obs_t mon_e, mon_g;
  int   pulses[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic r_prev = 1'b0;

  bit m_act = 1'b0;
  int m_j = 0, m_n = 0, m_h = 1, m_g = 1;

  // Cycle j after the accepting edge, computed from the press timing rules.
  function automatic obs_t expect_at(input int j, input int n, input int h, input int g);
    obs_t o;
    int per, t;
    per = h + g;
    t = n * per;
    o = '0;
    if (j < t) begin
      o.bp   = ((j % per) < h);
      o.busy = 1'b1;
      o.left = 4'(n - 1 - j / per);
    end else begin
      o.done = (j == t);
    end
    return o;
  endfunction

  always @(posedge clk) r_prev <= buttonPressed;

  always @(negedge clk) begin
    if (r_prev && !buttonPressed) pulses.push_back(cyc);
    if (mon_en && q.size() > 0) begin
      mon_e = q.pop_front();
      mon_g = {buttonPressed, busy, done, presses_left};
      n_cmp++;
      if (mon_g !== mon_e) begin
        n_bad++;
        $display("FAIL cycle %0d: got bp=%b busy=%b done=%b left=%0d, want bp=%b busy=%b done=%b left=%0d",
                 cyc, mon_g.bp, mon_g.busy, mon_g.done, mon_g.left,
                 mon_e.bp, mon_e.busy, mon_e.done, mon_e.left);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic step(input bit s, input bit a, input int n, input int h, input int g);
    obs_t e;
    start       = s;
    abort       = a;
    press_count = 4'(n);
    hold_cycles = 8'(h);
    gap_cycles  = 8'(g);
    if (m_act && m_j < m_n * (m_h + m_g)) begin
      if (a) begin
        m_act = 1'b0;
        e = '0;
      end else begin
        m_j++;
        e = expect_at(m_j, m_n, m_h, m_g);
      end
    end else if (s && !a) begin
      m_act = 1'b1;
      m_n = n;
      m_h = (h == 0) ? 1 : h;
      m_g = (g == 0) ? 1 : g;
      m_j = 0;
      e = expect_at(0, m_n, m_h, m_g);
    end else begin
      m_act = 1'b0;
      e = '0;
    end
    @(posedge clk);
    cyc++;
    q.push_back(e);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic loopback(input int abort_at);
    int e0c;
    pulses.delete();
    step(1'b1, 1'b0, 3, 4, 2);
    e0c = cyc;
    for (int i = 1; i <= 20; i++) step(1'b0, (i == abort_at), 0, 0, 0);
    if (abort_at == 0) begin
      chk("lb_count", pulses.size(), 3);
      for (int k = 0; k < 3; k++)
        chk("lb_pulse_cycle", (k < pulses.size()) ? pulses[k] : -1, e0c + 4 + 6 * k);
    end else begin
      chk("lb_abort_count", pulses.size(), 1);
      chk("lb_abort_cycle", (pulses.size() > 0) ? pulses[0] : -1, e0c + abort_at);
    end
  endtask

  bit rs, ra;
  int rn, rh, rg;

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_init_bp", int'(buttonPressed), 0);
    chk("rst_init_busy", int'(busy), 0);
    chk("rst_init_left", int'(presses_left), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 1'b1;
    idle(3);

    // Basic sequence, then a back-to-back start in the done cycle.
    step(1'b1, 1'b0, 2, 3, 2);
    idle(10);
    step(1'b1, 1'b0, 1, 2, 1);
    idle(5);

    // Zero hold/gap, then a zero press count.
    step(1'b1, 1'b0, 1, 0, 0);
    idle(4);
    step(1'b1, 1'b0, 0, 7, 7);
    idle(3);

    // Starts with other parameters during a busy sequence.
    step(1'b1, 1'b0, 2, 3, 2);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 5, 1, 1);
    idle(3);

    // Abort during the second press of three.
    step(1'b1, 1'b0, 3, 3, 2);
    idle(5);
    step(1'b0, 1'b1, 0, 0, 0);
    idle(4);
    step(1'b1, 1'b1, 2, 2, 2);
    idle(3);

    loopback(0);
    idle(2);
    loopback(2);
    idle(2);

    // Asynchronous reset in the middle of a hold.
    step(1'b1, 1'b0, 2, 5, 2);
    idle(2);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_mid_bp", int'(buttonPressed), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_left", int'(presses_left), 0);
    q.delete();
    @(posedge clk);
    #1;
    chk("rst_hold_bp", int'(buttonPressed), 0);
    reset = 1'b1;
    m_act = 1'b0;
    mon_en = 1'b1;
    idle(4);

    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 3) == 0);
      ra = ($urandom_range(0, 24) == 0);
      rn = $urandom_range(0, 4);
      rh = $urandom_range(0, 4);
      rg = $urandom_range(0, 3);
      step(rs, ra, rn, rh, rg);
    end
    idle(60);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
